// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stopwatch_ctrl_if : buttons, digit flags and digit-block controls  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface stopwatch_ctrl_if #(
  parameter int N = 4
);
  logic         ss;
  logic         lc;
  logic [N-1:0] cnt_9;
  logic [N-1:0] enb;
  logic         cnt_clr;
  logic         ld;
  logic         running;
  logic         lap;

  modport master (
    input  ss, lc, cnt_9,
    output enb, cnt_clr, ld, running, lap
  );

  modport slave (
    output ss, lc, cnt_9,
    input  enb, cnt_clr, ld, running, lap
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stopwatch_ctrl : mode FSM, tick prescaler and BCD cascade enables  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module stopwatch_ctrl #(
  parameter int N   = 4,
  parameter int DIV = 50_000_000
) (
  input  wire logic        ck,
  input  wire logic        rst_s,
  stopwatch_ctrl_if.master bus
);

  localparam int                 c_PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAP  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_ss_q;
  logic               r_lc_q;
  logic               w_ss_ev;
  logic               w_lc_ev;
  logic [c_PRE_W-1:0] r_pre;
  logic               w_tick;
  logic               w_counting;
  logic               w_ld;
  logic               w_lap;
  logic               w_clr_nxt;
  logic               r_cnt_clr;
  logic [N-1:0]       w_chain;

  // Previous samples reset high so a button held through reset is not an event.
  always_ff @(posedge ck) begin
    if (rst_s) begin
      r_ss_q <= 1'b1;
      r_lc_q <= 1'b1;
    end else begin
      r_ss_q <= bus.ss;
      r_lc_q <= bus.lc;
    end
  end

  assign w_ss_ev = bus.ss & ~r_ss_q;
  assign w_lc_ev = bus.lc & ~r_lc_q & ~w_ss_ev;

  always_ff @(posedge ck) begin
    if (rst_s) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = 1'b0;
    w_counting  = 1'b0;
    w_ld        = 1'b1;
    w_lap       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss_ev) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_counting = 1'b1;
        if (w_ss_ev)      w_state_nxt = S_STOP;
        else if (w_lc_ev) w_state_nxt = S_LAP;
      end
      S_LAP: begin
        w_counting = 1'b1;
        w_ld       = 1'b0;
        w_lap      = 1'b1;
        if (w_ss_ev)      w_state_nxt = S_STOP;
        else if (w_lc_ev) w_state_nxt = S_RUN;
      end
      S_STOP: begin
        if (w_ss_ev) begin
          w_state_nxt = S_RUN;
        end else if (w_lc_ev) begin
          w_state_nxt = S_IDLE;
          w_clr_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // STOP keeps the partial second so a pause does not lose time.
  always_ff @(posedge ck) begin
    if (rst_s || (r_state == S_IDLE)) begin
      r_pre <= '0;
    end else if (w_counting) begin
      r_pre <= (r_pre == c_PRE_MAX) ? '0 : r_pre + c_PRE_W'(1);
    end
  end

  assign w_tick = w_counting & (r_pre == c_PRE_MAX);

  always_ff @(posedge ck) begin
    if (rst_s) begin
      r_cnt_clr <= 1'b1;
    end else begin
      r_cnt_clr <= w_clr_nxt;
    end
  end

  assign w_chain[0] = 1'b1;

  // Digit i advances only when every lower digit is about to wrap.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_enb
      if (gi > 0) begin : g_carry
        assign w_chain[gi] = w_chain[gi-1] & bus.cnt_9[gi-1];
      end
      assign bus.enb[gi] = w_tick & w_chain[gi];
    end
  endgenerate

  assign bus.cnt_clr = r_cnt_clr;
  assign bus.ld      = w_ld;
  assign bus.running = w_counting;
  assign bus.lap     = w_lap;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_stopwatch_ctrl : two digit blocks, random buttons, mode model   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_stopwatch_ctrl;

  localparam int N   = 2;
  localparam int DIV = 4;
  localparam int MOD = 100;

  typedef enum int {M_IDLE, M_RUN, M_LAP, M_STOP} mode_t;

  logic ck;
  logic rst_s;

  stopwatch_ctrl_if #(.N(N)) bus ();

  stopwatch_ctrl #(.N(N), .DIV(DIV)) u_dut (
    .ck    (ck),
    .rst_s (rst_s),
    .bus   (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Digit blocks: counter plus display register per digit.
  logic [3:0] r_dig  [N];
  logic [3:0] r_disp [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      r_dig[i]  = 4'd0;
      r_disp[i] = 4'd0;
    end
  end

  always @(posedge ck) begin
    for (int i = 0; i < N; i++) begin
      if (bus.cnt_clr === 1'b1)      r_dig[i] <= 4'd0;
      else if (bus.enb[i] === 1'b1)  r_dig[i] <= (r_dig[i] == 4'd9) ? 4'd0 : r_dig[i] + 4'd1;
      if (bus.ld === 1'b1)           r_disp[i] <= r_dig[i];
    end
  end

  always_comb begin
    bus.cnt_9 = '0;
    for (int i = 0; i < N; i++) bus.cnt_9[i] = (r_dig[i] == 4'd9);
  end

  // Reference model: mode, prescaler position and elapsed seconds as integers.
  mode_t m_mode  = M_IDLE;
  int    m_pre   = 0;
  int    m_sec   = 0;
  int    m_disp  = 0;
  bit    m_clr   = 1'b0;
  bit    m_ssq   = 1'b1;
  bit    m_lcq   = 1'b1;
  bit    m_valid = 1'b0;

  function automatic bit m_tick();
    return ((m_mode == M_RUN) || (m_mode == M_LAP)) && (m_pre == DIV - 1);
  endfunction

  function automatic int m_enb();
    int v = 0;
    int p = 1;
    if (m_tick()) begin
      for (int i = 0; i < N; i++) begin
        if (m_sec % p == p - 1) v = v | (1 << i);
        p = p * 10;
      end
    end
    return v;
  endfunction

  always @(posedge ck) begin : p_model
    bit l_tick;
    bit l_ss_ev;
    bit l_lc_ev;
    l_tick = m_tick();
    if (m_mode != M_LAP) m_disp = m_sec;
    if (m_clr)       m_sec = 0;
    else if (l_tick) m_sec = (m_sec + 1) % MOD;
    if (rst_s) begin
      m_mode  = M_IDLE;
      m_pre   = 0;
      m_ssq   = 1'b1;
      m_lcq   = 1'b1;
      m_clr   = 1'b1;
      m_valid = 1'b1;
    end else begin
      l_ss_ev = bus.ss && !m_ssq;
      l_lc_ev = bus.lc && !m_lcq;
      m_ssq   = bus.ss;
      m_lcq   = bus.lc;
      m_clr   = (m_mode == M_STOP) && l_lc_ev && !l_ss_ev;
      case (m_mode)
        M_IDLE: m_pre = 0;
        M_STOP: m_pre = m_pre;
        default: m_pre = (m_pre + 1) % DIV;
      endcase
      if (l_ss_ev) begin
        m_mode = (m_mode == M_RUN || m_mode == M_LAP) ? M_STOP : (m_mode == M_IDLE || m_mode == M_STOP) ? M_RUN : m_mode;
      end else if (l_lc_ev) begin
        case (m_mode)
          M_RUN:   m_mode = M_LAP;
          M_LAP:   m_mode = M_RUN;
          M_STOP:  m_mode = M_IDLE;
          default: m_mode = m_mode;
        endcase
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  always @(negedge ck) begin
    int l_cnt;
    int l_dsp;
    if (m_valid) begin
      l_cnt = 0;
      l_dsp = 0;
      for (int i = N - 1; i >= 0; i--) begin
        l_cnt = l_cnt * 10 + int'(r_dig[i]);
        l_dsp = l_dsp * 10 + int'(r_disp[i]);
      end
      chk_eq("enb",     int'(bus.enb),     m_enb());
      chk_eq("cnt_clr", int'(bus.cnt_clr), int'(m_clr));
      chk_eq("ld",      int'(bus.ld),      int'(m_mode != M_LAP));
      chk_eq("running", int'(bus.running), int'((m_mode == M_RUN) || (m_mode == M_LAP)));
      chk_eq("lap",     int'(bus.lap),     int'(m_mode == M_LAP));
      chk_eq("count",   l_cnt,             m_sec);
      chk_eq("display", l_dsp,             m_disp);
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge ck);
  endtask

  task automatic pulse(input bit p_ss, input bit p_lc);
    bus.ss = p_ss;
    bus.lc = p_lc;
    @(negedge ck);
    bus.ss = 1'b0;
    bus.lc = 1'b0;
  endtask

  initial begin
    rst_s  = 1'b1;
    bus.ss = 1'b1;
    bus.lc = 1'b1;
    wait_n(3);
    rst_s = 1'b0;
    wait_n(3);
    bus.ss = 1'b0;
    bus.lc = 1'b0;
    wait_n(2);

    pulse(1'b1, 1'b0);
    wait_n(60);
    wait_n(360);

    pulse(1'b0, 1'b1);
    wait_n(14);
    pulse(1'b0, 1'b1);
    wait_n(6);

    pulse(1'b1, 1'b0);
    wait_n(7);
    pulse(1'b1, 1'b0);
    wait_n(9);
    pulse(1'b1, 1'b0);
    wait_n(3);
    pulse(1'b0, 1'b1);
    wait_n(5);

    pulse(1'b0, 1'b1);
    wait_n(4);

    pulse(1'b1, 1'b0);
    wait_n(10);
    pulse(1'b1, 1'b1);
    wait_n(4);
    pulse(1'b1, 1'b0);
    wait_n(6);
    bus.ss = 1'b1;
    wait_n(10);
    bus.ss = 1'b0;
    wait_n(5);

    pulse(1'b1, 1'b0);
    wait_n(150);
    pulse(1'b0, 1'b1);
    wait_n(5);
    bus.ss = 1'b1;
    rst_s  = 1'b1;
    wait_n(1);
    rst_s = 1'b0;
    wait_n(4);
    bus.ss = 1'b0;
    wait_n(4);

    for (int c = 0; c < 900; c++) begin
      rst_s = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 5) == 0) bus.ss = ~bus.ss;
      if ($urandom_range(0, 5) == 0) bus.lc = ~bus.lc;
      @(negedge ck);
    end
    rst_s  = 1'b0;
    bus.ss = 1'b0;
    bus.lc = 1'b0;
    wait_n(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
